// File: rtl/game_timer_pkg.sv
// Shared types, 7-segment encodings and BCD limits for the game round timers.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  // Active-low segments, bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] MAX_MIN  = 4'd9;
  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/game_countdown_tick_divider.sv
// Down-counting clock divider: one-cycle tick every CLK_FREQ enabled cycles.
module tick_divider #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic Clck,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [W-1:0] RELOAD = W'(CLK_FREQ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - W'(1);
    end
  end

  always_ff @(posedge Clck or posedge reset) begin
    if (reset) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_countdown.sv
// M:SS BCD round countdown timer with registered active-low 7-segment outputs
// and a one-cycle time_up pulse at 0:00.
module game_countdown
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned PRESET_MIN  = 1,
  parameter int unsigned PRESET_TENS = 0,
  parameter int unsigned PRESET_ONES = 0
) (
  input  logic       Clck,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       running,
  output logic       time_up
);

  localparam logic [3:0] PRE_MIN  = 4'(PRESET_MIN);
  localparam logic [3:0] PRE_TENS = 4'(PRESET_TENS);
  localparam logic [3:0] PRE_ONES = 4'(PRESET_ONES);

  state_e     state_q, state_d;
  logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0] len_min_q, len_min_d, len_tens_q, len_tens_d, len_ones_q, len_ones_d;
  logic       time_up_q, time_up_d;
  logic [6:0] hex0_q, hex1_q, hex2_q;
  logic       tick;
  logic       div_run, div_restart;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic [3:0] ld_min, ld_tens, ld_ones;

  // PAUSED with pause released counts as running, so a pause costs exactly
  // the number of cycles it is held high.
  assign div_run     = ((state_q == RUN) || (state_q == PAUSED)) && !pause;
  assign div_restart = (state_q == IDLE) || (state_q == EXPIRED);

  tick_divider #(
    .CLK_FREQ(CLK_FREQ)
  ) u_div (
    .Clck   (Clck),
    .reset  (reset),
    .run    (div_run),
    .restart(div_restart),
    .tick   (tick)
  );

  assign ld_min  = clamp_digit(load_min,  MAX_MIN);
  assign ld_tens = clamp_digit(load_tens, MAX_TENS);
  assign ld_ones = clamp_digit(load_ones, MAX_ONES);

  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = MAX_ONES;
      dec_tens = tens_q - 4'd1;
    end else begin
      dec_ones = MAX_ONES;
      dec_tens = MAX_TENS;
      dec_min  = min_q - 4'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    len_min_d  = len_min_q;
    len_tens_d = len_tens_q;
    len_ones_d = len_ones_q;
    time_up_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          len_min_d  = ld_min;
          len_tens_d = ld_tens;
          len_ones_d = ld_ones;
          min_d      = ld_min;
          tens_d     = ld_tens;
          ones_d     = ld_ones;
        end else if (start) begin
          if ((min_q | tens_q | ones_q) != 4'd0) begin
            state_d = RUN;
          end else begin
            state_d   = EXPIRED;
            time_up_d = 1'b1;
          end
        end else if (clear) begin
          min_d  = len_min_q;
          tens_d = len_tens_q;
          ones_d = len_ones_q;
        end
      end

      RUN, PAUSED: begin
        if (clear) begin
          state_d = IDLE;
          min_d   = len_min_q;
          tens_d  = len_tens_q;
          ones_d  = len_ones_q;
        end else if (pause) begin
          state_d = PAUSED;
        end else begin
          state_d = RUN;
          if (tick) begin
            min_d  = dec_min;
            tens_d = dec_tens;
            ones_d = dec_ones;
            if ((dec_min | dec_tens | dec_ones) == 4'd0) begin
              state_d   = EXPIRED;
              time_up_d = 1'b1;
            end
          end
        end
      end

      EXPIRED: begin
        if (load) begin
          state_d    = IDLE;
          len_min_d  = ld_min;
          len_tens_d = ld_tens;
          len_ones_d = ld_ones;
          min_d      = ld_min;
          tens_d     = ld_tens;
          ones_d     = ld_ones;
        end else if (clear) begin
          state_d = IDLE;
          min_d   = len_min_q;
          tens_d  = len_tens_q;
          ones_d  = len_ones_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clck or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      min_q      <= PRE_MIN;
      tens_q     <= PRE_TENS;
      ones_q     <= PRE_ONES;
      len_min_q  <= PRE_MIN;
      len_tens_q <= PRE_TENS;
      len_ones_q <= PRE_ONES;
      time_up_q  <= 1'b0;
      hex0_q     <= seg7(PRE_ONES);
      hex1_q     <= seg7(PRE_TENS);
      hex2_q     <= seg7(PRE_MIN);
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      len_min_q  <= len_min_d;
      len_tens_q <= len_tens_d;
      len_ones_q <= len_ones_d;
      time_up_q  <= time_up_d;
      hex0_q     <= seg7(ones_q);
      hex1_q     <= seg7(tens_q);
      hex2_q     <= seg7(min_q);
    end
  end

  assign HEX0    = hex0_q;
  assign HEX1    = hex1_q;
  assign HEX2    = hex2_q;
  assign running = (state_q == RUN);
  assign time_up = time_up_q;

endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown at CLK_FREQ=4 with default 1:00 preset.
module tb_game_countdown;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       Clck = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_min = '0;
  logic [3:0] load_tens = '0;
  logic [3:0] load_ones = '0;
  logic [6:0] HEX0, HEX1, HEX2;
  logic       running, time_up;

  int n_checks = 0;
  int n_pass   = 0;

  game_countdown #(
    .CLK_FREQ   (4),
    .PRESET_MIN (1),
    .PRESET_TENS(0),
    .PRESET_ONES(0)
  ) dut (
    .Clck     (Clck),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .load     (load),
    .load_min (load_min),
    .load_tens(load_tens),
    .load_ones(load_ones),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .running  (running),
    .time_up  (time_up)
  );

  always #5 Clck = ~Clck;

  typedef struct {
    logic [3:0] mn;
    logic [3:0] tn;
    logic [3:0] on;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clck);
    #1;
  endtask

  task automatic do_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    load_min = m; load_tens = t; load_ones = o; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic chk_hex(input string name, input logic [6:0] e2, input logic [6:0] e1,
                         input logic [6:0] e0);
    chk({name, ".HEX2"}, 32'(HEX2), 32'(e2));
    chk({name, ".HEX1"}, 32'(HEX1), 32'(e1));
    chk({name, ".HEX0"}, 32'(HEX0), 32'(e0));
  endtask

  initial begin
    int first;
    int pulses;
    logic [6:0] h2s, h1s, h0s;

    vecs[0] = '{4'd1,  4'd2,  4'd3,  S1, S2, S3};
    vecs[1] = '{4'd4,  4'd5,  4'd6,  S4, S5, S6};
    vecs[2] = '{4'd7,  4'd0,  4'd8,  S7, S0, S8};
    vecs[3] = '{4'd12, 4'd7,  4'd11, S9, S5, S9};
    vecs[4] = '{4'd15, 4'd15, 4'd15, S9, S5, S9};
    vecs[5] = '{4'd0,  4'd6,  4'd9,  S0, S5, S9};
    vecs[6] = '{4'd8,  4'd4,  4'd10, S8, S4, S9};

    // Reset state, observed without any clock edge.
    #1 reset = 1'b1;
    #2;
    chk_hex("reset", S1, S0, S0);
    chk("reset.running", 32'(running), 32'd0);
    chk("reset.time_up", 32'(time_up), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);

    // Full default 1:00 round: 60 s * 4 cycles = 240 edges after the start edge.
    pulse_start();
    chk("run.running", 32'(running), 32'd1);
    first = 0; pulses = 0; h2s = '1; h1s = '1; h0s = '1;
    for (int k = 1; k <= 260; k++) begin
      step(1);
      if (time_up) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 5) chk_hex("run.0:59", S0, S5, S9);
      if (k == 241) begin
        h2s = HEX2; h1s = HEX1; h0s = HEX0;
      end
    end
    chk("run.first_time_up", 32'(first), 32'd240);
    chk("run.pulse_count", 32'(pulses), 32'd1);
    chk_hex("run.0:00", h2s, h1s, h0s);
    chk_hex("run.0:00_exp", S0, S0, S0);
    chk("run.end_running", 32'(running), 32'd0);
    pulse_clear();
    step(1);
    chk_hex("clear.restore", S1, S0, S0);

    // Load vectors in IDLE, including clamping.
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].mn, vecs[i].tn, vecs[i].on);
      step(1);
      chk_hex($sformatf("load[%0d]", i), vecs[i].h2, vecs[i].h1, vecs[i].h0);
    end

    // Borrow across tens: 0:10 -> 0:09.
    do_load(4'd0, 4'd1, 4'd0);
    pulse_start();
    step(5);
    chk_hex("borrow.0:09", S0, S0, S9);
    pulse_clear();
    step(1);
    chk_hex("borrow.clear", S0, S1, S0);

    // Pause 10 cycles after the first tick of a 0:03 round: expiry moves 12 -> 22.
    do_load(4'd0, 4'd0, 4'd3);
    pulse_start();
    first = 0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (k == 5) pause = 1'b1;
      if (k == 15) pause = 1'b0;
      if (time_up) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 12) begin
        chk_hex("pause.frozen", S0, S0, S2);
        chk("pause.running", 32'(running), 32'd0);
      end
    end
    chk("pause.first_time_up", 32'(first), 32'd22);
    chk("pause.pulse_count", 32'(pulses), 32'd1);
    pulse_clear();

    // Zero-length round: immediate expiry, start ignored in EXPIRED.
    do_load(4'd0, 4'd0, 4'd0);
    step(1);
    pulse_start();
    chk("zero.time_up", 32'(time_up), 32'd1);
    chk("zero.running", 32'(running), 32'd0);
    step(1);
    chk("zero.pulse_end", 32'(time_up), 32'd0);
    pulses = 0;
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      start = 1'b0;
      if (time_up) pulses++;
    end
    chk("zero.restart_ignored", 32'(pulses), 32'd0);
    pulse_clear();
    step(1);
    chk_hex("zero.idle", S0, S0, S0);
    pulse_start();
    chk("zero.idle_start", 32'(time_up), 32'd1);
    pulse_clear();

    // Load and start together: load applies, start dropped.
    load_min = 4'd0; load_tens = 4'd0; load_ones = 4'd5;
    load = 1'b1; start = 1'b1;
    step(1);
    load = 1'b0; start = 1'b0;
    chk("ldst.running", 32'(running), 32'd0);
    step(1);
    chk_hex("ldst.0:05", S0, S0, S5);

    // Async reset mid-run.
    pulse_start();
    step(5);
    chk_hex("rst.pre_0:04", S0, S0, S4);
    #2 reset = 1'b1;
    #1;
    chk_hex("rst.async", S1, S0, S0);
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.time_up", 32'(time_up), 32'd0);
    step(2);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (time_up) pulses++;
    end
    chk("rst.no_time_up", 32'(pulses), 32'd0);
    chk_hex("rst.hold", S1, S0, S0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
